disp_mux: RTL

Time-multiplexed six-digit seven-segment display driver for the digital clock. Consumes the BCD hour/minute/second digits produced by the clock counters and scans them onto a common-anode display: one digit slot at a time, one digit active per slot. A frame-synchronous snapshot prevents torn readings across digit boundaries. Also provides leading-zero blanking and field blinking for time-set mode.

---
 rtl/disp_pkg.sv | 31 +++
 rtl/bcd_to_7seg.sv | 28 ++
 rtl/disp_mux.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared constants for the seven-segment display driver: segment patterns,
// anode encodings and the blink field selector.
package disp_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [5:0] ANODE_OFF = 6'h3F;

    typedef enum logic [1:0] {
        BLINK_NONE    = 2'b00,
        BLINK_HOURS   = 2'b01,
        BLINK_MINUTES = 2'b10,
        BLINK_SECONDS = 2'b11
    } blink_sel_e;

    // Active-low one-hot anode for a slot; slot 0 is the leftmost digit.
    function automatic logic [5:0] anode_onehot(input logic [2:0] slot);
        return ~(6'b000001 << slot);
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder {g,f,e,d,c,b,a};
// non-decimal codes decode to a dark digit.
module bcd_to_7seg
    import disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Pattern lookup.
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/disp_mux.sv
// Six-digit time-multiplexed common-anode display driver with per-frame
// snapshot of the time digits, leading-zero blanking and field blinking.
module disp_mux
    import disp_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 128
) (
    input  logic       dm_clock,
    input  logic       dm_reset,
    input  logic       dm_enable,
    input  logic [1:0] dm_h_msd,
    input  logic [3:0] dm_h_lsd,
    input  logic [2:0] dm_m_msd,
    input  logic [3:0] dm_m_lsd,
    input  logic [2:0] dm_s_msd,
    input  logic [3:0] dm_s_lsd,
    input  logic [1:0] dm_blink_sel,
    input  logic       dm_lz_blank,
    output logic [6:0] dm_seg,
    output logic [5:0] dm_an,
    output logic       dm_dp,
    output logic       dm_frame
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [3:0]    sh0_q, sh1_q, sh2_q, sh3_q, sh4_q, sh5_q;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          phase_q, phase_d;
    logic [6:0]    seg_q, seg_d;
    logic [5:0]    an_q, an_d;
    logic          dp_q, dp_d;
    logic          frame_q, frame_d;

    logic          snap_s;
    logic [3:0]    digit_s;
    logic [6:0]    dec_seg_s;
    blink_sel_e    field_s;
    logic          blanked_s;
    logic          lz_s;

    assign snap_s = dm_enable && (idx_q == 3'd0) && (presc_q == PW'(0));

    // Slot digit and the blink field that slot belongs to.
    always_comb begin
        digit_s = 4'hF;
        field_s = BLINK_NONE;
        case (idx_q)
            3'd0:    begin digit_s = sh0_q; field_s = BLINK_HOURS;   end
            3'd1:    begin digit_s = sh1_q; field_s = BLINK_HOURS;   end
            3'd2:    begin digit_s = sh2_q; field_s = BLINK_MINUTES; end
            3'd3:    begin digit_s = sh3_q; field_s = BLINK_MINUTES; end
            3'd4:    begin digit_s = sh4_q; field_s = BLINK_SECONDS; end
            3'd5:    begin digit_s = sh5_q; field_s = BLINK_SECONDS; end
            default: begin digit_s = 4'hF;  field_s = BLINK_NONE;    end
        endcase
    end

    bcd_to_7seg u_dec (
        .bcd_i (digit_s),
        .seg_o (dec_seg_s)
    );

    assign blanked_s = phase_q && (field_s != BLINK_NONE)
                       && (field_s == blink_sel_e'(dm_blink_sel));
    assign lz_s      = dm_lz_blank && (idx_q == 3'd0) && (sh0_q == 4'd0);

    // Scan position and blink state advance.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (dm_enable) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = PW'(0);
                idx_d   = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
            if (snap_s) begin
                if (fcnt_q == FRAME_LAST) begin
                    fcnt_d  = FW'(0);
                    phase_d = ~phase_q;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end else begin
                fcnt_d = fcnt_q;
            end
        end else begin
            presc_d = presc_q;
        end
    end

    // Next output values; the first cycle of each slot keeps anodes off so the
    // previous slot's segments never ghost onto the new digit.
    always_comb begin
        seg_d   = SEG_BLANK;
        an_d    = ANODE_OFF;
        dp_d    = 1'b1;
        frame_d = 1'b0;
        if (dm_enable) begin
            seg_d   = (blanked_s || lz_s) ? SEG_BLANK : dec_seg_s;
            an_d    = (presc_q == PW'(0)) ? ANODE_OFF : anode_onehot(idx_q);
            dp_d    = ((idx_q == 3'd1) || (idx_q == 3'd3)) ? blanked_s : 1'b1;
            frame_d = snap_s;
        end else begin
            frame_d = 1'b0;
        end
    end

    // State, shadow and output registers.
    always_ff @(posedge dm_clock) begin
        if (dm_reset) begin
            presc_q <= PW'(0);
            idx_q   <= 3'd0;
            sh0_q   <= 4'd0;
            sh1_q   <= 4'd0;
            sh2_q   <= 4'd0;
            sh3_q   <= 4'd0;
            sh4_q   <= 4'd0;
            sh5_q   <= 4'd0;
            fcnt_q  <= FW'(0);
            phase_q <= 1'b0;
            seg_q   <= SEG_BLANK;
            an_q    <= ANODE_OFF;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
            frame_q <= frame_d;
            if (snap_s) begin
                sh0_q <= {2'b00, dm_h_msd};
                sh1_q <= dm_h_lsd;
                sh2_q <= {1'b0, dm_m_msd};
                sh3_q <= dm_m_lsd;
                sh4_q <= {1'b0, dm_s_msd};
                sh5_q <= dm_s_lsd;
            end
        end
    end

    assign dm_seg   = seg_q;
    assign dm_an    = an_q;
    assign dm_dp    = dp_q;
    assign dm_frame = frame_q;

endmodule
